// File: rtl/management_tx_frame_buffer.sv
// Management-bus frame buffer: bytes written one at a time over the register
// bus are packed big-endian into a word RAM, then streamed out as one frame.
module management_tx_frame_buffer #(
    parameter int          MAX_FRAME_BYTES = 1536,
    parameter logic [15:0] ADDR_DATA       = 16'h0100,
    parameter logic [15:0] ADDR_COMMIT     = 16'h0101,
    parameter logic [15:0] ADDR_DISCARD    = 16'h0102
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic        tx_data_valid,
    output logic [2:0]  tx_bytes_valid,
    output logic [31:0] tx_data,
    output logic        tx_commit,
    output logic        tx_busy,
    output logic        tx_overflow,
    output logic [10:0] frame_len
);

    localparam int DEPTH  = MAX_FRAME_BYTES / 4;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        START,
        SEND,
        COMMIT
    } state_t;

    state_t              state_q, state_d;
    logic [10:0]         len_q, len_d;
    logic                ovf_q, ovf_d;
    logic [ADDR_W-1:0]   word_q, word_d;

    logic [31:0]         mem [DEPTH];
    logic [31:0]         rd_data_q;
    logic                mem_we;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;

    logic                data_hit, commit_hit, discard_hit;
    logic                full;
    logic [ADDR_W:0]     word_nxt;
    logic                is_last;
    logic [2:0]          last_bv;

    assign data_hit    = wr_en && (wr_addr == ADDR_DATA);
    assign commit_hit  = wr_en && (wr_addr == ADDR_COMMIT);
    assign discard_hit = wr_en && (wr_addr == ADDR_DISCARD);
    assign full        = (len_q == 11'(MAX_FRAME_BYTES));

    // The word being sent is the last one once (word+1)*4 covers frame_len.
    assign word_nxt = {1'b0, word_q} + (ADDR_W+1)'(1);
    assign is_last  = ({word_nxt, 2'b00} >= {1'b0, len_q});
    assign last_bv  = (len_q[1:0] == 2'd0) ? 3'd4 : {1'b0, len_q[1:0]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        word_d  = word_q;
        mem_we  = 1'b0;
        rd_en   = 1'b0;
        rd_addr = word_nxt[ADDR_W-1:0];
        case (state_q)
            IDLE: begin
                if (data_hit) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        len_d  = len_q + 11'd1;
                    end
                end else if (commit_hit && (len_q != 11'd0)) begin
                    state_d = WAIT_READY;
                end else if (discard_hit) begin
                    len_d = 11'd0;
                    ovf_d = 1'b0;
                end
            end
            WAIT_READY: begin
                if (data_hit) ovf_d = 1'b1;
                if (tx_ready) state_d = START;
            end
            START: begin
                if (data_hit) ovf_d = 1'b1;
                rd_en   = 1'b1;
                rd_addr = '0;
                word_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                if (data_hit) ovf_d = 1'b1;
                if (is_last) begin
                    state_d = COMMIT;
                end else begin
                    rd_en  = 1'b1;
                    word_d = word_nxt[ADDR_W-1:0];
                end
            end
            COMMIT: begin
                // The returning-to-idle clear wins over a late data write here.
                state_d = IDLE;
                len_d   = 11'd0;
                ovf_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= 11'd0;
            ovf_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            word_q  <= word_d;
        end
    end

    // Byte-lane write into the word at frame_len/4; lane 0 is the MSB byte.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && (len_q[1:0] == 2'(b))) begin
                mem[len_q[ADDR_W+1:2]][8*(3-b) +: 8] <= wr_data;
            end
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign tx_start       = (state_q == START);
    assign tx_data_valid  = (state_q == SEND);
    assign tx_commit      = (state_q == COMMIT);
    assign tx_busy        = (state_q != IDLE);
    assign tx_overflow    = ovf_q;
    assign frame_len      = len_q;
    assign tx_bytes_valid = !tx_data_valid ? 3'd0 : (is_last ? last_bv : 3'd4);

    // Stale RAM bytes past the frame end are masked off.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign tx_data[31-8*gi -: 8] = (tx_bytes_valid > 3'(gi))
                                           ? rd_data_q[31-8*gi -: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: tb/tb_management_tx_frame_buffer.sv
// Directed bench for management_tx_frame_buffer: builds frames over the
// register bus and checks the streamed words, strobes and status.
module tb_management_tx_frame_buffer;

    localparam logic [15:0] A_DATA    = 16'h0100;
    localparam logic [15:0] A_COMMIT  = 16'h0101;
    localparam logic [15:0] A_DISCARD = 16'h0102;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        tx_ready;
    logic        tx_start;
    logic        tx_data_valid;
    logic [2:0]  tx_bytes_valid;
    logic [31:0] tx_data;
    logic        tx_commit;
    logic        tx_busy;
    logic        tx_overflow;
    logic [10:0] frame_len;

    management_tx_frame_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .tx_ready       (tx_ready),
        .tx_start       (tx_start),
        .tx_data_valid  (tx_data_valid),
        .tx_bytes_valid (tx_bytes_valid),
        .tx_data        (tx_data),
        .tx_commit      (tx_commit),
        .tx_busy        (tx_busy),
        .tx_overflow    (tx_overflow),
        .frame_len      (frame_len)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        mon_en = 1'b0;
    logic [31:0] words [$];
    logic [2:0]  bvs [$];
    int          wcyc [$];
    int          n_start = 0;
    int          n_commit = 0;
    int          start_cyc = 0;
    int          commit_cyc = 0;
    int          viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_start) begin
                n_start++;
                start_cyc = cyc;
            end
            if (tx_data_valid) begin
                words.push_back(tx_data);
                bvs.push_back(tx_bytes_valid);
                wcyc.push_back(cyc);
            end
            if (tx_commit) begin
                n_commit++;
                commit_cyc = cyc;
                $display("frame: commit after %0d words", words.size());
            end
            if (!tx_data_valid && (tx_data !== 32'h0 || tx_bytes_valid !== 3'd0)) viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic clear_mon();
        words.delete();
        bvs.delete();
        wcyc.delete();
        n_start  = 0;
        n_commit = 0;
    endtask

    task automatic wait_commit(input string tag, input int limit);
        int k = 0;
        while (n_commit == 0 && k < limit) begin
            tick();
            k++;
        end
        check({tag, "_commit_seen"}, n_commit, 1);
        tick();
    endtask

    task automatic check_frame(input string tag, input int nw);
        check({tag, "_nwords"}, words.size(), nw);
        check({tag, "_nstart"}, n_start, 1);
        check({tag, "_first_cyc"}, wcyc.size() > 0 ? wcyc[0] : -1, start_cyc + 1);
        check({tag, "_last_cyc"}, wcyc.size() > 0 ? wcyc[wcyc.size()-1] : -1, start_cyc + nw);
        check({tag, "_commit_cyc"}, commit_cyc, start_cyc + nw + 1);
        check({tag, "_len_after"}, frame_len, 0);
        check({tag, "_ovf_after"}, tx_overflow, 0);
        check({tag, "_busy_after"}, tx_busy, 0);
    endtask

    initial begin
        int rc;
        int bad;
        int k;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; tx_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        mon_en = 1'b1;
        check("rst_len", frame_len, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_ovf", tx_overflow, 0);
        check("rst_outs", {tx_start, tx_data_valid, tx_commit, tx_bytes_valid}, 0);

        // Five-byte frame, downstream ready throughout.
        tx_ready = 1'b1;
        clear_mon();
        for (int i = 1; i <= 5; i++) bus_write(A_DATA, 8'(i));
        check("f5_len", frame_len, 5);
        bus_write(A_COMMIT, 8'h00);
        wait_commit("f5", 50);
        check_frame("f5", 2);
        check("f5_w0", words.size() > 0 ? words[0] : 32'hx, 32'h01020304);
        check("f5_bv0", bvs.size() > 0 ? bvs[0] : 3'bx, 4);
        check("f5_w1", words.size() > 1 ? words[1] : 32'hx, 32'h05000000);
        check("f5_bv1", bvs.size() > 1 ? bvs[1] : 3'bx, 1);

        // Commit held off by tx_ready for 10 cycles.
        tx_ready = 1'b0;
        clear_mon();
        bus_write(A_DATA, 8'hAA);
        bus_write(A_COMMIT, 8'h00);
        repeat (10) tick();
        check("wr_no_start", n_start, 0);
        check("wr_busy", tx_busy, 1);
        tx_ready = 1'b1;
        rc = cyc;
        wait_commit("wr", 50);
        check("wr_start_lat", start_cyc, rc + 1);
        check_frame("wr", 1);
        check("wr_w0", words.size() > 0 ? words[0] : 32'hx, 32'hAA000000);
        check("wr_bv0", bvs.size() > 0 ? bvs[0] : 3'bx, 1);

        // Overfill: 1537 bytes into a 1536-byte buffer.
        clear_mon();
        for (int i = 0; i < 1537; i++) bus_write(A_DATA, 8'(i));
        check("full_len", frame_len, 1536);
        check("full_ovf", tx_overflow, 1);
        bus_write(A_COMMIT, 8'h00);
        wait_commit("full", 600);
        check_frame("full", 384);
        bad = 0;
        foreach (bvs[i]) if (bvs[i] != 3'd4) bad++;
        check("full_bv_not4", bad, 0);
        check("full_w0", words.size() > 0 ? words[0] : 32'hx, 32'h00010203);
        check("full_w383", words.size() > 383 ? words[383] : 32'hx, 32'hFCFDFEFF);

        // Empty commit, foreign address, discard.
        clear_mon();
        bus_write(A_COMMIT, 8'h00);
        repeat (5) tick();
        check("empty_start", n_start, 0);
        check("empty_words", words.size(), 0);
        check("empty_busy", tx_busy, 0);
        for (int i = 0; i < 3; i++) bus_write(A_DATA, 8'h30 + 8'(i));
        bus_write(16'h0200, 8'h55);
        check("other_len", frame_len, 3);
        bus_write(A_DISCARD, 8'h00);
        check("disc_len", frame_len, 0);

        // Data write while sending is dropped and flagged.
        clear_mon();
        for (int i = 0; i < 12; i++) bus_write(A_DATA, 8'h11 + 8'(i));
        bus_write(A_COMMIT, 8'h00);
        k = 0;
        while (words.size() == 0 && k < 20) begin
            tick();
            k++;
        end
        bus_write(A_DATA, 8'hEE);
        check("ds_ovf", tx_overflow, 1);
        check("ds_len", frame_len, 12);
        wait_commit("ds", 50);
        check_frame("ds", 3);
        check("ds_w0", words.size() > 0 ? words[0] : 32'hx, 32'h11121314);
        check("ds_w1", words.size() > 1 ? words[1] : 32'hx, 32'h15161718);
        check("ds_w2", words.size() > 2 ? words[2] : 32'hx, 32'h191A1B1C);
        check("ds_bv2", bvs.size() > 2 ? bvs[2] : 3'bx, 4);

        // Reset on the second word of a frame.
        clear_mon();
        for (int i = 0; i < 12; i++) bus_write(A_DATA, 8'h40 + 8'(i));
        bus_write(A_COMMIT, 8'h00);
        k = 0;
        while (words.size() < 2 && k < 20) begin
            tick();
            k++;
        end
        check("rs_words_before", words.size(), 2);
        rst = 1'b1;
        tick();
        check("rs_outs", {tx_start, tx_data_valid, tx_commit, tx_busy, tx_overflow}, 0);
        check("rs_data", tx_data, 0);
        check("rs_bv", tx_bytes_valid, 0);
        check("rs_len", frame_len, 0);
        rst = 1'b0;
        repeat (5) tick();
        check("rs_no_commit", n_commit, 0);
        check("rs_idle", tx_busy, 0);

        check("idle_zero", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
